// File: rtl/fb_pkg.sv
// Shared constants, types and helpers for the frame-buffer pixel fetch path.
// Logical frame is 320x240, pixels packed {R[3:0],G[3:0],B[3:0]}.
package fb_pkg;

    localparam int PIX_W  = 12;
    localparam int ADDR_W = 17;
    localparam int CH_W   = 4;

    localparam logic [8:0] H_RES = 9'd320;
    localparam logic [8:0] V_RES = 9'd240;

    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam pix_t BAR_WHITE   = 12'hFFF;
    localparam pix_t BAR_YELLOW  = 12'hFF0;
    localparam pix_t BAR_CYAN    = 12'h0FF;
    localparam pix_t BAR_GREEN   = 12'h0F0;
    localparam pix_t BAR_MAGENTA = 12'hF0F;
    localparam pix_t BAR_RED     = 12'hF00;
    localparam pix_t BAR_BLUE    = 12'h00F;
    localparam pix_t BAR_BLACK   = 12'h000;

    // Control bits that travel alongside a pixel through the RAM latency.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic use_ram;
    } ctrl_t;

    // 40-pixel colour bands picked by threshold compares, no divider.
    function automatic pix_t bar_color(input logic [8:0] x);
        if      (x < 9'd40)  return BAR_WHITE;
        else if (x < 9'd80)  return BAR_YELLOW;
        else if (x < 9'd120) return BAR_CYAN;
        else if (x < 9'd160) return BAR_GREEN;
        else if (x < 9'd200) return BAR_MAGENTA;
        else if (x < 9'd240) return BAR_RED;
        else if (x < 9'd280) return BAR_BLUE;
        else                 return BAR_BLACK;
    endfunction

    // y*320 + x as two shifts and adds.
    function automatic addr_t pix_addr(input logic [8:0] x, input logic [8:0] y);
        return (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/fb_pixel_fetch_if.sv
// Read port between the pixel fetch block and the synchronous frame-buffer RAM.
interface fb_pixel_fetch_if;
    import fb_pkg::*;

    logic  rd_en;
    addr_t rd_addr;
    pix_t  rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/fb_delay_line.sv
// Fixed-depth shift register with asynchronous reset; DEPTH must be >= 1.
module fb_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: every stage is reset (these are flops, not a RAM), so reset flushes the pipe to blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/fb_pixel_fetch.sv
// Turns logical pixel positions into frame-buffer reads and drives blanked RGB plus
// syncs aligned to the RAM latency; also colour bars and a frame counter.
module fb_pixel_fetch
    import fb_pkg::*;
#(
    parameter int   RD_LATENCY   = 1,       // legal range 1..4
    parameter pix_t BORDER_COLOR = 12'h000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [8:0]               pos_x_div,
    input  logic [8:0]               pos_y_div,
    input  logic                     active,
    input  logic                     i_hsync,
    input  logic                     i_vsync,
    input  logic                     test_mode,
    fb_pixel_fetch_if.master         ram,
    output logic [CH_W-1:0]          o_red,
    output logic [CH_W-1:0]          o_green,
    output logic [CH_W-1:0]          o_blue,
    output logic                     o_hsync,
    output logic                     o_vsync,
    output logic                     o_active,
    output logic                     frame_start,
    output logic [7:0]               frame_cnt
);

    logic [8:0] x_q, x_d, y_q, y_d;
    logic       active_q, active_d, hsync_q, hsync_d, vsync_q, vsync_d, test_q, test_d;
    logic       rd_en_q, rd_en_d;
    addr_t      rd_addr_q, rd_addr_d;
    pix_t       rgb_q, rgb_d;
    logic       o_hsync_q, o_hsync_d, o_vsync_q, o_vsync_d, o_active_q, o_active_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    logic  in_range;
    ctrl_t ctrl_s0, ctrl_dl;
    pix_t  color_s0, color_dl;

    // NOTE: all outputs get a value before any branch, so no latch can be inferred.
    always_comb begin
        x_d      = pos_x_div;
        y_d      = pos_y_div;
        active_d = active;
        hsync_d  = i_hsync;
        vsync_d  = i_vsync;
        test_d   = test_mode;

        in_range  = (x_q < H_RES) && (y_q < V_RES);
        rd_en_d   = active_q && in_range && !test_q;
        rd_addr_d = rd_en_d ? pix_addr(x_q, y_q) : rd_addr_q;

        // Everything except live RAM data is decided here and delayed alongside.
        color_s0 = '0;
        if (active_q) begin
            if (!in_range)   color_s0 = BORDER_COLOR;
            else if (test_q) color_s0 = bar_color(x_q);
        end
        ctrl_s0 = '{hsync: hsync_q, vsync: vsync_q, active: active_q, use_ram: rd_en_d};

        rgb_d         = ctrl_dl.use_ram ? ram.rd_data : color_dl;
        o_hsync_d     = ctrl_dl.hsync;
        o_vsync_d     = ctrl_dl.vsync;
        o_active_d    = ctrl_dl.active;
        frame_start_d = ctrl_dl.vsync && !o_vsync_q;
        frame_cnt_d   = frame_cnt_q + 8'(frame_start_d);
    end

    fb_delay_line #(.WIDTH($bits(ctrl_t)), .DEPTH(1 + RD_LATENCY)) u_ctrl_dl (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ctrl_s0),
        .dout (ctrl_dl)
    );

    fb_delay_line #(.WIDTH(PIX_W), .DEPTH(1 + RD_LATENCY)) u_color_dl (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (color_s0),
        .dout (color_dl)
    );

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            active_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            test_q        <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            rgb_q         <= '0;
            o_hsync_q     <= 1'b0;
            o_vsync_q     <= 1'b0;
            o_active_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            test_q        <= test_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            rgb_q         <= rgb_d;
            o_hsync_q     <= o_hsync_d;
            o_vsync_q     <= o_vsync_d;
            o_active_q    <= o_active_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign ram.rd_en   = rd_en_q;
    assign ram.rd_addr = rd_addr_q;
    assign o_red       = rgb_q[R_LSB +: CH_W];
    assign o_green     = rgb_q[G_LSB +: CH_W];
    assign o_blue      = rgb_q[B_LSB +: CH_W];
    assign o_hsync     = o_hsync_q;
    assign o_vsync     = o_vsync_q;
    assign o_active    = o_active_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_fb_pixel_fetch.sv
// Bench for fb_pixel_fetch: directed vector table, hand sequences for sync/frame/reset
// corners, and random traffic against a history-based reference model.
module tb_fb_pixel_fetch;

    localparam logic [11:0] BORDER = 12'h5A5;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic       act;
        logic       hs;
        logic       vs;
        logic       tm;
    } in_t;

    typedef struct {
        in_t         in;
        logic        en;
        logic [16:0] addr;
        logic [11:0] rgb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  pos_x_div, pos_y_div;
    logic        active, i_hsync, i_vsync, test_mode;
    logic [3:0]  o_red, o_green, o_blue;
    logic        o_hsync, o_vsync, o_active, frame_start;
    logic [7:0]  frame_cnt;

    int passed = 0;
    int total  = 0;

    in_t         hist[$];
    logic [16:0] m_addr;
    logic [7:0]  m_cnt;
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};
    vec_t        tbl[$];

    always #5 clk = ~clk;

    fb_pixel_fetch_if ram ();

    fb_pixel_fetch #(.RD_LATENCY(1), .BORDER_COLOR(BORDER)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pos_x_div  (pos_x_div),
        .pos_y_div  (pos_y_div),
        .active     (active),
        .i_hsync    (i_hsync),
        .i_vsync    (i_vsync),
        .test_mode  (test_mode),
        .ram        (ram),
        .o_red      (o_red),
        .o_green    (o_green),
        .o_blue     (o_blue),
        .o_hsync    (o_hsync),
        .o_vsync    (o_vsync),
        .o_active   (o_active),
        .frame_start(frame_start),
        .frame_cnt  (frame_cnt)
    );

    // Frame-buffer contents: low address bits folded with the upper ones.
    function automatic logic [11:0] ram_word(input logic [16:0] a);
        return a[11:0] ^ {7'd0, a[16:12]};
    endfunction

    // One-cycle-latency RAM; returns all-ones garbage when not read.
    always @(posedge clk) ram.rd_data <= ram.rd_en ? ram_word(ram.rd_addr) : 12'hFFF;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, got, exp);
    endtask

    function automatic in_t past(input int k);
        if (hist.size() > k) return hist[hist.size() - 1 - k];
        return '0;
    endfunction

    function automatic logic ref_en(input in_t v);
        return v.act && v.x < 320 && v.y < 240 && !v.tm;
    endfunction

    function automatic logic [16:0] ref_addr(input in_t v);
        return 17'(int'(v.y) * 320 + int'(v.x));
    endfunction

    function automatic logic [11:0] ref_rgb(input in_t v);
        if (!v.act) return 12'h000;
        if (v.x >= 320 || v.y >= 240) return BORDER;
        if (v.tm) return bars[int'(v.x) / 40];
        return ram_word(ref_addr(v));
    endfunction

    function automatic logic [63:0] outs();
        return 64'({ram.rd_en, ram.rd_addr, o_red, o_green, o_blue,
                    o_hsync, o_vsync, o_active, frame_start, frame_cnt});
    endfunction

    // Reads fire one edge after sampling; everything visible appears three edges after.
    task automatic model_check();
        in_t  a, b, c;
        logic en, fs;
        a  = past(1);
        b  = past(3);
        c  = past(4);
        en = ref_en(a);
        if (en) m_addr = ref_addr(a);
        fs = b.vs && !c.vs;
        if (fs) m_cnt = m_cnt + 8'd1;
        check("model", outs(), 64'({en, m_addr, ref_rgb(b), b.hs, b.vs, b.act, fs, m_cnt}));
    endtask

    task automatic drive(input in_t v);
        pos_x_div = v.x;
        pos_y_div = v.y;
        active    = v.act;
        i_hsync   = v.hs;
        i_vsync   = v.vs;
        test_mode = v.tm;
        @(posedge clk);
        hist.push_back(v);
        if (hist.size() > 8) void'(hist.pop_front());
        @(negedge clk);
        model_check();
    endtask

    function automatic in_t mk(input int x, input int y, input logic act, input logic tm);
        in_t v;
        v     = '0;
        v.x   = 9'(x);
        v.y   = 9'(y);
        v.act = act;
        v.tm  = tm;
        return v;
    endfunction

    task automatic add(input int x, input int y, input logic act, input logic tm,
                       input logic en, input int addr, input logic [11:0] rgb);
        vec_t e;
        e.in   = mk(x, y, act, tm);
        e.en   = en;
        e.addr = 17'(addr);
        e.rgb  = rgb;
        tbl.push_back(e);
    endtask

    task automatic restart_model();
        hist.delete();
        m_addr = '0;
        m_cnt  = '0;
    endtask

    initial begin
        in_t  idle, v;
        int   pulses, lat;
        logic vs_state, tm_state;

        idle = '0;
        rst_n = 1'b0;
        pos_x_div = '0; pos_y_div = '0;
        active = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0; test_mode = 1'b0;
        restart_model();

        //     x    y   act tm  en  addr   rgb
        add(  5,   2,  1, 0,  1,   645, 12'h285);
        add(319, 239,  1, 0,  1, 76799, 12'hBED);
        add(  0,   0,  1, 0,  1,     0, 12'h000);
        add(100, 100,  1, 0,  1, 32100, 12'hD63);
        add(  5,   2,  0, 0,  0,     0, 12'h000);
        add(330,   2,  1, 0,  0,     0, BORDER);
        add(  5, 240,  1, 0,  0,     0, BORDER);
        add(  0,  10,  1, 1,  0,     0, 12'hFFF);
        add( 39,  10,  1, 1,  0,     0, 12'hFFF);
        add( 40,  10,  1, 1,  0,     0, 12'hFF0);
        add( 80,  10,  1, 1,  0,     0, 12'h0FF);
        add(160,  10,  1, 1,  0,     0, 12'hF0F);
        add(200,  10,  1, 1,  0,     0, 12'hF00);
        add(279,  10,  1, 1,  0,     0, 12'h00F);
        add(280,  10,  1, 1,  0,     0, 12'h000);
        add(319,  10,  1, 1,  0,     0, 12'h000);
        add(330,  10,  1, 1,  0,     0, BORDER);
        add(100,  10,  0, 1,  0,     0, 12'h000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", outs(), 64'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            drive(idle);
            check("tbl_rd_en", 64'(ram.rd_en), 64'(tbl[i].en));
            if (tbl[i].en) check("tbl_rd_addr", 64'(ram.rd_addr), 64'(tbl[i].addr));
            drive(idle);
            drive(idle);
            check("tbl_rgb", 64'({o_red, o_green, o_blue}), 64'(tbl[i].rgb));
        end

        // Single-cycle hsync must reappear exactly three edges later, for one cycle.
        v = idle;
        v.hs = 1'b1;
        drive(v);
        for (int k = 1; k <= 4; k++) begin
            drive(idle);
            check("hsync_align", 64'(o_hsync), 64'(k == 3));
        end

        pulses = 0;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 20; c++) begin
                v = idle;
                v.vs = (c < 10);
                drive(v);
                if (frame_start) pulses++;
            end
        end
        for (int c = 0; c < 4; c++) begin
            drive(idle);
            if (frame_start) pulses++;
        end
        check("frame_pulses", 64'(pulses), 64'd3);
        check("frame_cnt_3", 64'(frame_cnt), 64'd3);

        for (int f = 0; f < 253; f++) begin
            for (int c = 0; c < 4; c++) begin
                v = idle;
                v.vs = (c < 2);
                drive(v);
            end
        end
        repeat (4) drive(idle);
        check("frame_cnt_wrap", 64'(frame_cnt), 64'd0);

        vs_state = 1'b0;
        tm_state = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 30) == 0) vs_state = ~vs_state;
            if ($urandom_range(0, 50) == 0) tm_state = ~tm_state;
            v.x   = 9'($urandom_range(0, 340));
            v.y   = 9'($urandom_range(0, 250));
            v.act = ($urandom_range(0, 3) != 0);
            v.hs  = ($urandom_range(0, 7) == 0);
            v.vs  = vs_state;
            v.tm  = tm_state;
            drive(v);
        end

        // Reset in the middle of live video, then relatch.
        for (int n = 0; n < 4; n++) drive(mk(10 + n, 20, 1'b1, 1'b0));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", outs(), 64'd0);
        @(negedge clk);
        check("reset_hold", outs(), 64'd0);
        rst_n = 1'b1;
        restart_model();
        drive(idle);
        drive(idle);
        lat = 0;
        do begin
            drive(mk(7, 3, 1'b1, 1'b0));
            lat++;
        end while (!o_active && lat < 10);
        // Sampling edge plus three cycles of latency.
        check("reset_first_active", 64'(lat), 64'd4);
        check("post_reset_rgb", 64'({o_red, o_green, o_blue}), 64'(ram_word(17'd967)));
        repeat (4) drive(idle);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fb_pixel_fetch.md
Name: fb_pixel_fetch

Overview:
- Downstream of display_cnt.
- Converts the divided pixel position (320x240 logical frame) into frame-buffer read addresses and issues reads to a synchronous frame-buffer RAM.
- Delays hsync/vsync/active to match RAM latency and drives blanked 4:4:4 RGB to the VGA pins.
- Also provides a colour-bar test mode plus a frame-start pulse and frame counter for the writer side.

Parameters:
- H_RES, 320, logical pixels per line.
- V_RES, 240, logical lines per frame.
- ADDR_W, 17, frame-buffer address width; must hold H_RES*V_RES-1.
- PIX_W, 12, pixel width; packing is {R[3:0],G[3:0],B[3:0]}.
- RD_LATENCY, 1, RAM read latency in cycles; legal range 1..4.
- BORDER_COLOR, 12'h000, colour output for active pixels outside the logical frame.

Ports:
- clk  in  1  pixel clock (25 MHz domain, same as display_cnt)
- rst_n  in  1  asynchronous active-low reset
- pos_x_div  in  9  logical x from display_cnt
- pos_y_div  in  9  logical y from display_cnt
- active  in  1  visible-area flag from display_cnt
- i_hsync  in  1  hsync from display_cnt, active-high
- i_vsync  in  1  vsync from display_cnt, active-high
- test_mode  in  1  1 = colour bars, 0 = RAM data; quasi-static
- rd_en  out  1  RAM read enable
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  PIX_W  RAM read data, valid RD_LATENCY cycles after rd_en
- o_red  out  4  red
- o_green  out  4  green
- o_blue  out  4  blue
- o_hsync  out  1  aligned hsync
- o_vsync  out  1  aligned vsync
- o_active  out  1  aligned visible flag
- frame_start  out  1  one-cycle pulse on aligned vsync rising edge
- frame_cnt  out  8  frames since reset, wraps

Behaviour:
- Reset (async assert on rst_n=0, release synchronous to clk): all registered outputs and internal pipeline state clear to 0.
  - rd_en=0, rd_addr=0, RGB=0.
  - o_hsync, o_vsync, o_active, frame_start = 0; frame_cnt=0.
- Total latency: input sample at edge n appears on the o_* outputs at edge n+2+RD_LATENCY (3 cycles at default). All of o_hsync, o_vsync, o_active and RGB share this latency exactly.
- Stage S0, edge n: register pos_x_div, pos_y_div, active, i_hsync, i_vsync and test_mode. Compute in_range = (x < H_RES) && (y < V_RES).
- Stage S1, edge n+1:
  - rd_addr <= y*320 + x, computed as (y<<8)+(y<<6)+x at ADDR_W bits, no overflow when in range.
  - rd_en <= active && in_range && !test_mode.
  - When rd_en=0, rd_addr holds its previous value.
- Stage S2, edge n+1+RD_LATENCY: rd_data is sampled. Control bits ride a shift register of depth 1+RD_LATENCY from S1.
- Output stage, edge n+2+RD_LATENCY:
  - active=0: RGB=0 (blanking is mandatory).
  - active=1 and !in_range: RGB=BORDER_COLOR.
  - active=1, in_range, test_mode=1: colour bar by x in 40-pixel bands. Bands 0..7 are FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000. Band is selected by comparison thresholds, not a divider.
  - Otherwise: RGB = rd_data.
- test_mode is pipelined with the pixel, so a toggle mid-line takes effect cleanly at the pixel where it was sampled.
- frame_start: 1 for exactly one cycle when aligned o_vsync goes 0->1. On the same edge, frame_cnt increments and wraps 255->0.
- Continuous-high vsync produces no further pulses.
- Reset mid-frame: pipeline flushes to blank. The first o_active=1 appears no earlier than 3 cycles after the first active=1 following release. frame_cnt restarts at 0.
- No backpressure; the RAM must accept one read per cycle.

Decomposition:
- Package fb_pkg holds:
  - H_RES, V_RES, PIX_W and ADDR_W constants;
  - the colour-bar palette constants;
  - the RGB packing field offsets.
- Sub-module fb_delay_line (parameterised width/depth shift register with async reset) is used both for the control pipeline and for the test-pattern colour path.

Test Plan:
- Address map: drive x=5,y=2,active=1 -> rd_en=1, rd_addr=645 one cycle later. Drive x=319,y=239 -> rd_addr=76799.
- Latency/alignment: RAM model returns rd_data=addr[11:0]; pulse i_hsync for one cycle at n -> o_hsync high at n+3 only. Pixel x=5,y=2 -> RGB=12'h285 at n+3.
- Blanking/border: active=0 with rd_data=FFF -> RGB=000 and rd_en=0. active=1, x=330 -> rd_en=0, RGB=BORDER_COLOR.
- Test mode: test_mode=1, x=0,39,40,279,280,319 -> RGB FFF, FFF, FF0, 00F, 000, 000, with rd_en=0 throughout.
- Frame counter: three i_vsync rising edges (each 2 lines high) -> three single-cycle frame_start pulses, frame_cnt=3. Run 256 frames -> frame_cnt wraps to 0.
- Reset mid-line: assert rst_n=0 during active video -> all outputs 0 immediately (async). After release, outputs stay blank until 3 cycles after the next active=1.
